// File: rtl/calc_port_responder.sv
// Two-operand command responder: captures cmd/op1, then op2, executes,
// and emits a one-cycle response. Vector bit 0 is the MSB.
module calc_port_responder #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    OP2,
    EXEC,
    RESP
  } state_t;

  localparam logic [1:0] LAST = 2'(EXEC_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cmd_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [1:0]  cnt_q;

  logic [32:0] sum;
  logic [31:0] diff;
  logic        is_add;
  logic        is_sub;
  logic        is_shl;
  logic        is_shr;
  logic [1:0]  res_code;
  logic [31:0] res_data;

  assign sum    = {1'b0, op1_q} + {1'b0, op2_q};
  assign diff   = op1_q - op2_q;
  assign is_add = (cmd_q == 4'd1);
  assign is_sub = (cmd_q == 4'd2);
  assign is_shl = (cmd_q == 4'd5);
  assign is_shr = (cmd_q == 4'd6);

  // Unknown commands and arithmetic faults share code 2 with zero data.
  always_comb begin
    res_code = 2'd2;
    res_data = 32'h0;
    unique case (1'b1)
      is_add: begin
        if (!sum[32]) begin
          res_code = 2'd1;
          res_data = sum[31:0];
        end
      end
      is_sub: begin
        if (op2_q <= op1_q) begin
          res_code = 2'd1;
          res_data = diff;
        end
      end
      is_shl: begin
        res_code = 2'd1;
        res_data = op1_q << op2_q[4:0];
      end
      is_shr: begin
        res_code = 2'd1;
        res_data = op1_q >> op2_q[4:0];
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= 4'd0;
      op1_q    <= 32'h0;
      op2_q    <= 32'h0;
      cnt_q    <= 2'd0;
      out_resp <= 2'd0;
      out_data <= 32'h0;
      busy     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_cmd_in != 4'd0) begin
            cmd_q   <= req_cmd_in;
            op1_q   <= req_data_in;
            busy    <= 1'b1;
            state_q <= OP2;
          end
        end
        OP2: begin
          op2_q   <= req_data_in;
          cnt_q   <= 2'd0;
          state_q <= EXEC;
        end
        EXEC: begin
          if (cnt_q == LAST) begin
            out_resp <= res_code;
            out_data <= res_data;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RESP: begin
          out_resp <= 2'd0;
          out_data <= 32'h0;
          busy     <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder at the default EXEC_CYCLES of 1.
// Expected values are hand-computed constants.
module tb_calc_port_responder;

  logic        c_clk;
  logic        reset;
  logic [0:3]  req_cmd_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        busy;

  int errors;
  int checks;

  calc_port_responder dut (
    .c_clk      (c_clk),
    .reset      (reset),
    .req_cmd_in (req_cmd_in),
    .req_data_in(req_data_in),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .busy       (busy)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Command in the current cycle N; response checked at N+3.
  task automatic run_op(input string tag, input logic [3:0] cmd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] er, input logic [31:0] ed);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    req_cmd_in  = cmd;
    req_data_in = a;
    tick();
    chk({tag, "_op2_busy"}, {31'd0, busy}, 32'd1);
    req_cmd_in  = 4'd0;
    req_data_in = b;
    tick();
    chk({tag, "_exec_resp"}, {30'd0, out_resp}, 32'd0);
    req_data_in = 32'h0;
    tick();
    chk({tag, "_resp"}, {30'd0, out_resp}, {30'd0, er});
    chk({tag, "_data"}, out_data, ed);
    tick();
    chk({tag, "_after_resp"}, {30'd0, out_resp}, 32'd0);
    chk({tag, "_after_data"}, out_data, 32'h0);
    chk({tag, "_after_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    req_cmd_in  = 4'd0;
    req_data_in = 32'h0;
    tick();
    tick();
    chk("rst_resp", {30'd0, out_resp}, 32'd0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Command in the last reset cycle must be ignored.
    req_cmd_in  = 4'd1;
    req_data_in = 32'h5;
    tick();
    chk("rst_cmd_ignored", {31'd0, busy}, 32'd0);
    reset      = 1'b0;
    req_cmd_in = 4'd0;

    run_op("add_basic", 4'd1, 32'h0000_0001, 32'h1FFF_FFFF,
           2'd1, 32'h2000_0000);
    run_op("add_ovf", 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0);
    run_op("sub_unf", 4'd2, 32'h1, 32'hF, 2'd2, 32'h0);
    run_op("sub_ok", 4'd2, 32'hF, 32'h1, 2'd1, 32'hE);
    run_op("sub_eq", 4'd2, 32'h1234_5678, 32'h1234_5678, 2'd1, 32'h0);
    run_op("shl_31", 4'd5, 32'h1, 32'hFFFF_FFFF, 2'd1, 32'h8000_0000);
    run_op("shl_hi_ign", 4'd5, 32'h3, 32'hFFFF_FFE4, 2'd1, 32'h30);
    run_op("shr_4", 4'd6, 32'h8000_0000, 32'h4, 2'd1, 32'h0800_0000);
    run_op("inv3", 4'd3, 32'h1, 32'h2, 2'd2, 32'h0);
    run_op("inv4", 4'd4, 32'h1, 32'h2, 2'd2, 32'h0);
    run_op("inv15", 4'd15, 32'hFF, 32'h1, 2'd2, 32'h0);

    // No-op in IDLE.
    req_cmd_in  = 4'd0;
    req_data_in = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nop_busy", {31'd0, busy}, 32'd0);
      chk("nop_resp", {30'd0, out_resp}, 32'd0);
    end

    // Commands during a busy operation are dropped.
    req_cmd_in  = 4'd1;
    req_data_in = 32'h5;
    tick();
    req_cmd_in  = 4'd2;
    req_data_in = 32'h7;
    tick();
    req_cmd_in  = 4'd2;
    req_data_in = 32'h9;
    tick();
    req_cmd_in  = 4'd0;
    req_data_in = 32'h0;
    chk("busy_drop_resp", {30'd0, out_resp}, 32'd1);
    chk("busy_drop_data", out_data, 32'hC);
    tick();
    chk("busy_drop_n4", {30'd0, out_resp}, 32'd0);
    chk("busy_drop_n4_busy", {31'd0, busy}, 32'd0);
    run_op("after_drop", 4'd2, 32'h9, 32'h4, 2'd1, 32'h5);

    // Reset in EXEC aborts; command while reset high is ignored.
    req_cmd_in  = 4'd1;
    req_data_in = 32'h1;
    tick();
    req_cmd_in  = 4'd0;
    req_data_in = 32'h2;
    tick();
    reset       = 1'b1;
    req_cmd_in  = 4'd5;
    req_data_in = 32'h1;
    tick();
    reset      = 1'b0;
    req_cmd_in = 4'd0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_resp", {30'd0, out_resp}, 32'd0);
      tick();
    end
    chk("abort_end_resp", {30'd0, out_resp}, 32'd0);
    run_op("post_abort", 4'd1, 32'h10, 32'h20, 2'd1, 32'h30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
